// File: rtl/tdm_receiver.sv
// -----------------------------------------------------------------------------
// tdm_receiver
//
// Receives a 32-timeslot serial TDM stream (8 bits per slot, MSB first) that
// is clocked by c4 at twice the bit rate, aligns to the active-low frame
// pulse f0 and hands completed timeslot bytes to a downstream consumer
// through a small FIFO with a valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH   output buffer depth in entries (power of two, >= 2)
//
// Ports
//   c4           in   bit clock (2x bit rate), all logic on posedge
//   reset_in_rg  in   asynchronous active-low reset
//   f0           in   frame pulse, active-low, one c4 cycle wide
//   data_from_dt in   serial TDM data, one bit per two c4 cycles
//   rx_ready     in   downstream can accept a byte this cycle
//   rx_valid     out  buffer head valid
//   rx_data      out  received timeslot byte at the buffer head
//   rx_chan      out  timeslot number (0..31) of rx_data
//   locked       out  frame alignment established
//   frame_err    out  one-cycle pulse after a misplaced f0 while locked
//   overflow     out  sticky: a byte was dropped because the buffer was full
// -----------------------------------------------------------------------------
module tdm_receiver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       c4,
    input  logic       reset_in_rg,
    input  logic       f0,
    input  logic       data_from_dt,
    input  logic       rx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic [4:0] rx_chan,
    output logic       locked,
    output logic       frame_err,
    output logic       overflow
);

    localparam int              PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]  C_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_ALIGN  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_miss;
    logic             r_locked;
    logic             r_frame_err;
    logic             r_overflow;
    logic [8:0]       r_cnt;
    logic [6:0]       r_sr;

    logic [7:0]       r_mem_data [FIFO_DEPTH];
    logic [4:0]       r_mem_chan [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_f0_hit;
    logic             w_at_end;
    logic             w_sample;
    logic             w_byte_done;
    logic [7:0]       w_byte;
    logic [4:0]       w_chan;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_wr_en;

    assign w_f0_hit    = ~f0;
    assign w_at_end    = (r_cnt == 9'd511);
    assign w_sample    = r_cnt[0];
    assign w_byte_done = (r_cnt[3:0] == 4'hF);
    // The LSB is taken straight from the line on the completing edge; the
    // seven earlier bits are already in the shift register, oldest = MSB.
    assign w_byte      = {r_sr, data_from_dt};
    assign w_chan      = r_cnt[8:4];

    // ---- Stage 1: frame counter and bit capture ----
    always_ff @(posedge c4 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else begin
            r_cnt <= w_f0_hit ? 9'd0 : r_cnt + 9'd1;
            if (w_sample) begin
                r_sr <= {r_sr[5:0], data_from_dt};
            end
        end
    end

    // ---- Stage 2: frame alignment FSM ----
    // A missed pulse is tolerated once; the miss flag is the single-bit
    // miss counter, and a second consecutive miss drops back to HUNT.
    always_ff @(posedge c4 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            r_state     <= S_HUNT;
            r_miss      <= 1'b0;
            r_locked    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_HUNT: begin
                    if (w_f0_hit) begin
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (w_f0_hit && w_at_end) begin
                        r_state  <= S_LOCKED;
                        r_locked <= 1'b1;
                        r_miss   <= 1'b0;
                    end
                end
                S_LOCKED: begin
                    if (w_f0_hit && !w_at_end) begin
                        r_state     <= S_ALIGN;
                        r_locked    <= 1'b0;
                        r_frame_err <= 1'b1;
                        r_miss      <= 1'b0;
                    end else if (!w_f0_hit && w_at_end) begin
                        if (r_miss) begin
                            r_state  <= S_HUNT;
                            r_locked <= 1'b0;
                            r_miss   <= 1'b0;
                        end else begin
                            r_miss <= 1'b1;
                        end
                    end else if (w_f0_hit) begin
                        r_miss <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_HUNT;
                    r_locked <= 1'b0;
                    r_miss   <= 1'b0;
                end
            endcase
        end
    end

    // ---- Stage 3: output buffer ----
    // Pushing uses the state before this edge, so the byte completing on the
    // edge that leaves LOCKED is still delivered. When full, a push is only
    // accepted if the head leaves on the same edge.
    assign w_push  = (r_state == S_LOCKED) && w_byte_done;
    assign w_full  = (r_count == C_FULL);
    assign w_pop   = rx_valid && rx_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge c4) begin
        if (w_wr_en) begin
            r_mem_data[r_wr_ptr] <= w_byte;
            r_mem_chan[r_wr_ptr] <= w_chan;
        end
    end

    always_ff @(posedge c4 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head fields are forced to zero while empty so the outputs read zero
    // after reset without having to clear the storage array.
    assign rx_valid  = (r_count != '0);
    assign rx_data   = rx_valid ? r_mem_data[r_rd_ptr] : 8'd0;
    assign rx_chan   = rx_valid ? r_mem_chan[r_rd_ptr] : 5'd0;
    assign locked    = r_locked;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_tdm_receiver.sv
module tb_tdm_receiver;

    localparam int DEPTH  = 4;
    localparam int M_NORM = 0;
    localparam int M_OMIT = 1;
    localparam int M_MIS  = 2;
    localparam int P_INC  = 0;
    localparam int P_AA   = 1;
    localparam int P_RND  = 2;

    logic       c4 = 1'b0;
    logic       rst_n;
    logic       f0;
    logic       din;
    logic       ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [4:0] rx_chan;
    logic       locked;
    logic       frame_err;
    logic       overflow;

    always #5 c4 = ~c4;

    tdm_receiver #(.FIFO_DEPTH(DEPTH)) dut (
        .c4          (c4),
        .reset_in_rg (rst_n),
        .f0          (f0),
        .data_from_dt(din),
        .rx_ready    (ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_chan     (rx_chan),
        .locked      (locked),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 = hunting, 1 = saw one pulse, 2 = locked. Bytes are predicted
    // from what the bench transmitted, not from the sampled line.
    typedef struct {
        logic [4:0] chan;
        logic [7:0] data;
    } byte_t;

    int         m_cnt;
    int         m_phase;
    int         m_miss;
    bit         m_ferr;
    bit         m_ovf;
    byte_t      m_q[$];
    logic [7:0] tx[32];

    function automatic void model_reset();
        m_cnt   = 0;
        m_phase = 0;
        m_miss  = 0;
        m_ferr  = 0;
        m_ovf   = 0;
        m_q.delete();
    endfunction

    function automatic void model_edge(bit f0v, bit rdy);
        bit    pop;
        bit    full;
        bit    hit;
        byte_t b;
        pop  = rdy && (m_q.size() > 0);
        full = (m_q.size() == DEPTH);
        hit  = !f0v;
        if (pop) void'(m_q.pop_front());
        if (m_phase == 2 && (m_cnt % 16) == 15) begin
            if (full && !pop) begin
                m_ovf = 1;
            end else begin
                b.chan = 5'(m_cnt / 16);
                b.data = tx[m_cnt / 16];
                m_q.push_back(b);
            end
        end
        m_ferr = 0;
        if (m_phase == 0) begin
            if (hit) m_phase = 1;
        end else if (m_phase == 1) begin
            if (hit && m_cnt == 511) begin
                m_phase = 2;
                m_miss  = 0;
            end
        end else begin
            if (hit && m_cnt != 511) begin
                m_ferr  = 1;
                m_phase = 1;
                m_miss  = 0;
            end else if (!hit && m_cnt == 511) begin
                m_miss++;
                if (m_miss == 2) begin
                    m_phase = 0;
                    m_miss  = 0;
                end
            end else if (hit) begin
                m_miss = 0;
            end
        end
        m_cnt = hit ? 0 : (m_cnt + 1) % 512;
    endfunction

    task automatic compare_all();
        check("rx_valid", rx_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("rx_data", rx_data, m_q[0].data);
            check("rx_chan", rx_chan, m_q[0].chan);
        end
        check("locked", locked, m_phase == 2);
        check("frame_err", frame_err, m_ferr);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic do_edge();
        @(posedge c4);
        model_edge(f0, ready);
        #1;
        compare_all();
    endtask

    task automatic set_inputs(input bit f0low, input bit rdy);
        f0    = !f0low;
        ready = rdy;
        din   = tx[m_cnt / 16][7 - ((m_cnt % 16) / 2)];
    endtask

    task automatic fill_tx(input int pat);
        for (int k = 0; k < 32; k++) begin
            case (pat)
                P_INC:   tx[k] = 8'(k + 16);
                P_AA:    tx[k] = 8'hAA;
                default: tx[k] = 8'($urandom);
            endcase
        end
    endtask

    // One frame span: from a cycle with cnt==0 to the next cycle with cnt==0.
    task automatic run_entry(input int mode, input int mispos, input int rmode,
                             input int pat, output int pops, output int ferrs);
        int n;
        bit lo;
        bit r;
        fill_tx(pat);
        pops  = 0;
        ferrs = 0;
        n     = 0;
        do begin
            lo = (mode == M_NORM && m_cnt == 511) || (mode == M_MIS && m_cnt == mispos);
            r  = (rmode == 2) ? ($urandom_range(0, 3) != 0) : (rmode != 0);
            set_inputs(lo, r);
            if (rx_valid && r) pops++;
            do_edge();
            if (frame_err) ferrs++;
            n++;
        end while (m_cnt != 0 && n < 600);
        check("entry_len_bound", n < 600, 1);
    endtask

    typedef struct {
        int mode;
        int mispos;
        int rmode;
        int pat;
        int exp_locked;
        int exp_pops;
        int exp_ferr;
    } entry_t;

    entry_t tbl[13];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_data"}, rx_data, 0);
        check({tag, "_chan"}, rx_chan, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pops;
        int         ferrs;
        int         stable_bad;
        bit         have;
        logic [7:0] hd;
        logic [4:0] hc;
        byte_t      popped[$];
        byte_t      pb;

        tbl[0]  = '{M_NORM, 0,   1, P_INC, 0, 0,  0};
        tbl[1]  = '{M_NORM, 0,   1, P_INC, 1, 0,  0};
        tbl[2]  = '{M_NORM, 0,   1, P_INC, 1, 31, 0};
        tbl[3]  = '{M_NORM, 0,   1, P_AA,  1, 32, 0};
        tbl[4]  = '{M_MIS,  300, 1, P_RND, 0, 19, 1};
        tbl[5]  = '{M_NORM, 0,   1, P_INC, 1, 0,  0};
        tbl[6]  = '{M_NORM, 0,   1, P_RND, 1, 31, 0};
        tbl[7]  = '{M_OMIT, 0,   1, P_INC, 1, 32, 0};
        tbl[8]  = '{M_OMIT, 0,   1, P_INC, 0, 32, 0};
        tbl[9]  = '{M_NORM, 0,   1, P_INC, 0, 1,  0};
        tbl[10] = '{M_NORM, 0,   1, P_INC, 1, 0,  0};
        tbl[11] = '{M_NORM, 0,   0, P_RND, 1, 0,  0};
        tbl[12] = '{M_NORM, 0,   1, P_INC, 1, 35, 0};

        rst_n = 1'b0;
        f0    = 1'b1;
        din   = 1'b0;
        ready = 1'b1;
        fill_tx(P_INC);
        model_reset();
        repeat (3) @(posedge c4);
        #1;
        check_reset_outputs("reset");
        @(negedge c4);
        rst_n = 1'b1;

        // Table: lock, AA pattern, misplaced f0, loss of lock, backpressure.
        for (int i = 0; i < 13; i++) begin
            run_entry(tbl[i].mode, tbl[i].mispos, tbl[i].rmode, tbl[i].pat, pops, ferrs);
            check($sformatf("tbl%0d_locked", i), locked, tbl[i].exp_locked);
            check($sformatf("tbl%0d_pops", i), pops, tbl[i].exp_pops);
            check($sformatf("tbl%0d_ferr", i), ferrs, tbl[i].exp_ferr);
        end

        // Backpressure for six byte times, then drain.
        fill_tx(P_RND);
        set_inputs(1'b0, 1'b1);
        do_edge();
        have       = 0;
        stable_bad = 0;
        hd         = '0;
        hc         = '0;
        while (m_cnt < 97) begin
            set_inputs(1'b0, 1'b0);
            do_edge();
            if (rx_valid) begin
                if (!have) begin
                    hd   = rx_data;
                    hc   = rx_chan;
                    have = 1;
                end else if (rx_data !== hd || rx_chan !== hc) begin
                    stable_bad++;
                end
            end
        end
        check("bp_stable", stable_bad, 0);
        check("bp_head_data", hd, tx[0]);
        check("bp_head_chan", hc, 0);
        check("bp_overflow", overflow, 1);
        do begin
            set_inputs(m_cnt == 511, 1'b1);
            if (rx_valid) begin
                pb.chan = rx_chan;
                pb.data = rx_data;
                popped.push_back(pb);
            end
            do_edge();
        end while (m_cnt != 0);
        check("bp_drain_count", popped.size(), 29);
        if (popped.size() > 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("bp_drain%0d_chan", k), popped[k].chan, k);
                check($sformatf("bp_drain%0d_data", k), popped[k].data, tx[k]);
            end
            check("bp_after_drop_chan", popped[4].chan, 6);
            check("bp_after_drop_data", popped[4].data, tx[6]);
        end

        // Reset mid-frame at cnt 200 with two bytes buffered.
        fill_tx(P_RND);
        while (m_cnt < 200) begin
            set_inputs(1'b0, m_cnt < 169);
            do_edge();
        end
        check("pre_rst_valid", rx_valid, 1);
        check("pre_rst_chan", rx_chan, 10);
        check("pre_rst_locked", locked, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        f0 = 1'b1;
        repeat (2) @(posedge c4);
        @(negedge c4);
        rst_n = 1'b1;
        model_reset();
        run_entry(M_NORM, 0, 1, P_RND, pops, ferrs);
        check("relock1_locked", locked, 0);
        check("relock1_pops", pops, 0);
        run_entry(M_NORM, 0, 1, P_RND, pops, ferrs);
        check("relock2_locked", locked, 1);
        check("relock2_pops", pops, 0);
        run_entry(M_NORM, 0, 1, P_INC, pops, ferrs);
        check("relock3_pops", pops, 31);

        // Randomized frames against the model.
        for (int i = 0; i < 45; i++) begin
            int sel;
            int md;
            sel = $urandom_range(0, 99);
            md  = (sel < 70) ? M_NORM : (sel < 85) ? M_OMIT : M_MIS;
            run_entry(md, $urandom_range(0, 510), 2, P_RND, pops, ferrs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
